// File: rtl/k_and_s_pkg.sv
// k_and_s_pkg: shared types and constants for the K&S data path.
//   decoded_instruction_type : decoder output, one value per instruction class
//   alu_op_t                 : 3-bit ALU operation driven by the control unit
//   OP_*                     : 8-bit opcodes found in IR[DATA_W-1:DATA_W-8]
package k_and_s_pkg;

  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNEG   = 5'd10,
    I_BOV    = 5'd11,
    I_BNOV   = 5'd12,
    I_BNNEG  = 5'd13,
    I_BNZERO = 5'd14,
    I_HALT   = 5'd15,
    I_XOR    = 5'd16,
    I_SHL    = 5'd17,
    I_SHR    = 5'd18
  } decoded_instruction_type;

  typedef enum logic [2:0] {
    ALU_OR   = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SHL  = 3'b101,
    ALU_SHR  = 3'b110,
    ALU_PASS = 3'b111
  } alu_op_t;

  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_XOR    = 8'hA5;
  localparam logic [7:0] OP_SHL    = 8'hA6;
  localparam logic [7:0] OP_SHR    = 8'hA7;
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BOV    = 8'h05;
  localparam logic [7:0] OP_BNOV   = 8'h06;
  localparam logic [7:0] OP_BNNEG  = 8'h0A;
  localparam logic [7:0] OP_BNZERO = 8'h0B;
  localparam logic [7:0] OP_HALT   = 8'hFF;

endpackage

// File: rtl/ks_data_path_gen_if.sv
// ks_data_path_gen_if: bundle between the K&S control unit / RAM (master)
// and the data path (slave).
//   master drives : branch, pc_enable, ir_enable, addr_sel, c_sel,
//                   write_reg_enable, flags_reg_enable, operation, data_in
//   slave drives  : decoded_instruction, zero_op, neg_op, unsigned_overflow,
//                   signed_overflow, ram_addr, data_out
interface ks_data_path_gen_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) ();
  import k_and_s_pkg::*;

  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  alu_op_t                 operation;
  logic [DATA_W-1:0]       data_in;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       data_out;

  modport master (
    output branch, pc_enable, ir_enable, addr_sel, c_sel,
           write_reg_enable, flags_reg_enable, operation, data_in,
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );

  modport slave (
    input  branch, pc_enable, ir_enable, addr_sel, c_sel,
           write_reg_enable, flags_reg_enable, operation, data_in,
    output decoded_instruction, zero_op, neg_op, unsigned_overflow,
           signed_overflow, ram_addr, data_out
  );
endinterface

// File: rtl/ks_alu.sv
// ks_alu: combinational ALU with flag precursors (flags are latched by the
// parent).
//   i_a, i_b  : operands (a is the shifted / passed operand)
//   i_op      : alu_op_t operation
//   o_alu_out : result
//   o_zero, o_neg, o_uov, o_sov : zero, sign, unsigned and signed overflow
module ks_alu
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  alu_op_t           i_op,
  output logic [DATA_W-1:0] o_alu_out,
  output logic              o_zero,
  output logic              o_neg,
  output logic              o_uov,
  output logic              o_sov
);

  localparam int MSB = DATA_W - 1;

  // One extra bit holds the carry out of the MSB.
  logic [DATA_W:0] w_add_ext;
  logic [DATA_W:0] w_sub_ext;
  logic [DATA_W-1:0] w_result;
  logic w_uov;
  logic w_sov;

  assign w_add_ext = {1'b0, i_a} + {1'b0, i_b};
  // a + ~b + 1: carry out set means no borrow, so borrow = ~carry.
  assign w_sub_ext = {1'b0, i_a} + {1'b0, ~i_b} + {{DATA_W{1'b0}}, 1'b1};

  // Result and overflow selection per operation.
  always_comb begin
    w_result = {DATA_W{1'b0}};
    w_uov    = 1'b0;
    w_sov    = 1'b0;
    case (i_op)
      ALU_OR:   w_result = i_a | i_b;
      ALU_ADD: begin
        w_result = w_add_ext[DATA_W-1:0];
        w_uov    = w_add_ext[DATA_W];
        // Same-sign operands giving a different-sign sum.
        w_sov    = (i_a[MSB] == i_b[MSB]) && (w_add_ext[MSB] != i_a[MSB]);
      end
      ALU_SUB: begin
        w_result = w_sub_ext[DATA_W-1:0];
        w_uov    = ~w_sub_ext[DATA_W];
        // Opposite-sign operands where the result sign differs from a.
        w_sov    = (i_a[MSB] != i_b[MSB]) && (w_sub_ext[MSB] != i_a[MSB]);
      end
      ALU_AND:  w_result = i_a & i_b;
      ALU_XOR:  w_result = i_a ^ i_b;
      ALU_SHL: begin
        w_result = {i_a[DATA_W-2:0], 1'b0};
        w_uov    = i_a[MSB];
      end
      ALU_SHR: begin
        w_result = {1'b0, i_a[DATA_W-1:1]};
        w_uov    = i_a[0];
      end
      ALU_PASS: w_result = i_a;
      default:  w_result = {DATA_W{1'b0}};
    endcase
  end

  assign o_alu_out = w_result;
  assign o_zero    = (w_result == {DATA_W{1'b0}});
  assign o_neg     = w_result[MSB];
  assign o_uov     = w_uov;
  assign o_sov     = w_sov;

endmodule

// File: rtl/ks_data_path_gen.sv
// ks_data_path_gen: parametrised K&S data path (PC, IR, decoder, register
// file, ALU, flag register, address and write-back muxes).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ks_data_path_gen_if.slave -- control strobes and RAM read
//                data in; decode, flags, RAM address and store data out
module ks_data_path_gen
  import k_and_s_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  ks_data_path_gen_if.slave   bus
);

  localparam int REG_W = $clog2(NUM_REGS);

  // Reject configurations whose instruction fields cannot fit under the
  // 8-bit opcode.
  if ((DATA_W < 16) || (NUM_REGS < 2) || ((NUM_REGS & (NUM_REGS - 1)) != 0) ||
      (3 * REG_W > DATA_W - 8) || (ADDR_W + REG_W > DATA_W - 8)) begin : g_illegal_params
    $error("ks_data_path_gen: illegal DATA_W/NUM_REGS/ADDR_W combination");
  end

  logic [DATA_W-1:0]       r_ir;
  logic [ADDR_W-1:0]       r_pc;
  logic [DATA_W-1:0]       r_regs [NUM_REGS];
  logic                    r_zero;
  logic                    r_neg;
  logic                    r_uov;
  logic                    r_sov;

  logic [7:0]              w_opcode;
  decoded_instruction_type w_instr;
  logic [REG_W-1:0]        w_a_addr;
  logic [REG_W-1:0]        w_b_addr;
  logic [REG_W-1:0]        w_c_addr;
  logic [ADDR_W-1:0]       w_mem_addr;
  logic [DATA_W-1:0]       w_bus_a;
  logic [DATA_W-1:0]       w_bus_b;
  logic [DATA_W-1:0]       w_bus_c;
  logic [DATA_W-1:0]       w_alu_out;
  logic                    w_zero;
  logic                    w_neg;
  logic                    w_uov;
  logic                    w_sov;
  logic                    w_unused_ir;

  assign w_opcode    = r_ir[DATA_W-1 -: 8];
  // Not every IR bit is a field in every configuration.
  assign w_unused_ir = ^r_ir;

  // Instruction decode; fields not used by an opcode stay 0.
  always_comb begin
    w_instr    = I_NOP;
    w_a_addr   = {REG_W{1'b0}};
    w_b_addr   = {REG_W{1'b0}};
    w_c_addr   = {REG_W{1'b0}};
    w_mem_addr = {ADDR_W{1'b0}};
    case (w_opcode)
      OP_LOAD: begin
        w_instr    = I_LOAD;
        w_c_addr   = r_ir[ADDR_W+REG_W-1:ADDR_W];
        w_mem_addr = r_ir[ADDR_W-1:0];
      end
      OP_STORE: begin
        w_instr    = I_STORE;
        w_a_addr   = r_ir[ADDR_W+REG_W-1:ADDR_W];
        w_mem_addr = r_ir[ADDR_W-1:0];
      end
      OP_MOVE: begin
        w_instr  = I_MOVE;
        w_c_addr = r_ir[2*REG_W-1:REG_W];
        w_a_addr = r_ir[REG_W-1:0];
        w_b_addr = r_ir[REG_W-1:0];
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
        case (w_opcode)
          OP_ADD:  w_instr = I_ADD;
          OP_SUB:  w_instr = I_SUB;
          OP_AND:  w_instr = I_AND;
          OP_OR:   w_instr = I_OR;
          OP_XOR:  w_instr = I_XOR;
          OP_SHL:  w_instr = I_SHL;
          OP_SHR:  w_instr = I_SHR;
          default: w_instr = I_NOP;
        endcase
        w_a_addr = r_ir[REG_W-1:0];
        w_b_addr = r_ir[2*REG_W-1:REG_W];
        w_c_addr = r_ir[3*REG_W-1:2*REG_W];
      end
      OP_BRANCH, OP_BZERO, OP_BNEG, OP_BOV, OP_BNOV, OP_BNNEG, OP_BNZERO: begin
        case (w_opcode)
          OP_BRANCH: w_instr = I_BRANCH;
          OP_BZERO:  w_instr = I_BZERO;
          OP_BNEG:   w_instr = I_BNEG;
          OP_BOV:    w_instr = I_BOV;
          OP_BNOV:   w_instr = I_BNOV;
          OP_BNNEG:  w_instr = I_BNNEG;
          OP_BNZERO: w_instr = I_BNZERO;
          default:   w_instr = I_NOP;
        endcase
        w_mem_addr = r_ir[ADDR_W-1:0];
      end
      OP_HALT: w_instr = I_HALT;
      default: w_instr = I_NOP;
    endcase
  end

  // Register file reads are plain array reads: a same-cycle write is only
  // visible after the edge.
  assign w_bus_a = r_regs[w_a_addr];
  assign w_bus_b = r_regs[w_b_addr];
  assign w_bus_c = bus.c_sel ? w_alu_out : bus.data_in;

  ks_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a       (w_bus_a),
    .i_b       (w_bus_b),
    .i_op      (bus.operation),
    .o_alu_out (w_alu_out),
    .o_zero    (w_zero),
    .o_neg     (w_neg),
    .o_uov     (w_uov),
    .o_sov     (w_sov)
  );

  // Instruction register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= {DATA_W{1'b0}};
    end else if (bus.ir_enable) begin
      r_ir <= bus.data_in;
    end
  end

  // Program counter: jump to the decoded address or increment with wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= {ADDR_W{1'b0}};
    end else if (bus.pc_enable) begin
      r_pc <= bus.branch ? w_mem_addr : (r_pc + {{(ADDR_W-1){1'b0}}, 1'b1});
    end
  end

  // Register file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (bus.write_reg_enable) begin
      r_regs[w_c_addr] <= w_bus_c;
    end
  end

  // Flag register: all four flags latch together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
      r_uov  <= 1'b0;
      r_sov  <= 1'b0;
    end else if (bus.flags_reg_enable) begin
      r_zero <= w_zero;
      r_neg  <= w_neg;
      r_uov  <= w_uov;
      r_sov  <= w_sov;
    end
  end

  assign bus.decoded_instruction = w_instr;
  assign bus.zero_op             = r_zero;
  assign bus.neg_op              = r_neg;
  assign bus.unsigned_overflow   = r_uov;
  assign bus.signed_overflow     = r_sov;
  assign bus.ram_addr            = bus.addr_sel ? w_mem_addr : r_pc;
  assign bus.data_out            = w_bus_a;

endmodule

// File: tb/tb_ks_data_path_gen.sv
// tb_ks_data_path_gen: directed self-checking bench acting as the K&S
// control unit for a default-size and a large-size data path.
module tb_ks_data_path_gen;
  import k_and_s_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ks_data_path_gen_if #(.DATA_W(16), .ADDR_W(5)) ifc ();
  ks_data_path_gen_if #(.DATA_W(32), .ADDR_W(8)) ifl ();

  ks_data_path_gen #(.DATA_W(16), .NUM_REGS(4), .ADDR_W(5)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  ks_data_path_gen #(.DATA_W(32), .NUM_REGS(8), .ADDR_W(8)) u_dut_large (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifl.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [15:0] instr);
    ifc.data_in   = instr;
    ifc.ir_enable = 1'b1;
    tick();
    ifc.ir_enable = 1'b0;
  endtask

  // LOAD Rr: c field is IR[6:5].
  task automatic set_reg(input int r, input logic [15:0] val);
    load_ir(16'h8100 | 16'(r << 5));
    ifc.data_in          = val;
    ifc.c_sel            = 1'b0;
    ifc.write_reg_enable = 1'b1;
    tick();
    ifc.write_reg_enable = 1'b0;
  endtask

  // STORE Rr: a field is IR[6:5], data_out shows the register.
  task automatic check_reg(input string tag, input int r, input logic [15:0] exp);
    load_ir(16'h8200 | 16'(r << 5));
    check_eq(tag, 64'(ifc.data_out), 64'(exp));
  endtask

  task automatic alu_exec(input logic [15:0] instr, input alu_op_t op);
    load_ir(instr);
    ifc.operation        = op;
    ifc.c_sel            = 1'b1;
    ifc.write_reg_enable = 1'b1;
    ifc.flags_reg_enable = 1'b1;
    tick();
    ifc.write_reg_enable = 1'b0;
    ifc.flags_reg_enable = 1'b0;
  endtask

  function automatic logic [3:0] flags();
    return {ifc.zero_op, ifc.neg_op, ifc.unsigned_overflow, ifc.signed_overflow};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    ifc.branch = 1'b0; ifc.pc_enable = 1'b0; ifc.ir_enable = 1'b0;
    ifc.addr_sel = 1'b0; ifc.c_sel = 1'b0; ifc.write_reg_enable = 1'b0;
    ifc.flags_reg_enable = 1'b0; ifc.operation = ALU_OR; ifc.data_in = 16'h0000;
    ifl.branch = 1'b0; ifl.pc_enable = 1'b0; ifl.ir_enable = 1'b0;
    ifl.addr_sel = 1'b0; ifl.c_sel = 1'b0; ifl.write_reg_enable = 1'b0;
    ifl.flags_reg_enable = 1'b0; ifl.operation = ALU_OR; ifl.data_in = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check_eq("rst_pc", 64'(ifc.ram_addr), 64'h0);
    check_eq("rst_dec", 64'(ifc.decoded_instruction), 64'(I_NOP));
    check_eq("rst_flags", 64'(flags()), 64'h0);
    check_eq("rst_dout", 64'(ifc.data_out), 64'h0);

    // ADD with signed overflow, then unsigned carry to zero
    set_reg(1, 16'h7FFF);
    set_reg(2, 16'h0001);
    load_ir(16'hA139);
    check_eq("dec_add", 64'(ifc.decoded_instruction), 64'(I_ADD));
    alu_exec(16'hA139, ALU_ADD);
    check_eq("add_sov_flags", 64'(flags()), 64'b0101);
    check_reg("add_sov_r3", 3, 16'h8000);
    set_reg(1, 16'hFFFF);
    alu_exec(16'hA139, ALU_ADD);
    check_eq("add_carry_flags", 64'(flags()), 64'b1010);
    check_reg("add_carry_r3", 3, 16'h0000);

    // SUB borrow and equal operands
    set_reg(1, 16'h0003);
    set_reg(2, 16'h0005);
    alu_exec(16'hA239, ALU_SUB);
    check_eq("sub_borrow_flags", 64'(flags()), 64'b0110);
    check_reg("sub_borrow_r3", 3, 16'hFFFE);
    set_reg(2, 16'h0003);
    alu_exec(16'hA239, ALU_SUB);
    check_eq("sub_eq_flags", 64'(flags()), 64'b1000);
    check_reg("sub_eq_r3", 3, 16'h0000);

    // Shifts
    set_reg(1, 16'h8001);
    alu_exec(16'hA639, ALU_SHL);
    check_eq("shl_flags", 64'(flags()), 64'b0010);
    check_reg("shl_r3", 3, 16'h0002);
    alu_exec(16'hA739, ALU_SHR);
    check_eq("shr_flags", 64'(flags()), 64'b0010);
    check_reg("shr_r3", 3, 16'h4000);

    // XOR
    set_reg(1, 16'hF0F0);
    set_reg(2, 16'hFF00);
    load_ir(16'hA539);
    check_eq("dec_xor", 64'(ifc.decoded_instruction), 64'(I_XOR));
    alu_exec(16'hA539, ALU_XOR);
    check_eq("xor_flags", 64'(flags()), 64'b0000);
    check_reg("xor_r3", 3, 16'h0FF0);

    // Flags hold without flags_reg_enable (0+0 would set zero)
    set_reg(1, 16'h0000);
    set_reg(2, 16'h0000);
    load_ir(16'hA139);
    ifc.operation = ALU_ADD; ifc.c_sel = 1'b1; ifc.write_reg_enable = 1'b1;
    tick();
    ifc.write_reg_enable = 1'b0;
    check_eq("flags_hold", 64'(flags()), 64'b0000);

    // Decode of other opcodes
    load_ir(16'h7700);
    check_eq("dec_unknown", 64'(ifc.decoded_instruction), 64'(I_NOP));
    load_ir(16'hFF00);
    check_eq("dec_halt", 64'(ifc.decoded_instruction), 64'(I_HALT));

    // Same-cycle write and read of R1 through MOVE R1,R1
    load_ir(16'h9105);
    check_eq("dec_move", 64'(ifc.decoded_instruction), 64'(I_MOVE));
    ifc.data_in = 16'h1234; ifc.c_sel = 1'b0; ifc.write_reg_enable = 1'b1;
    @(negedge clk);
    check_eq("wr_rd_old", 64'(ifc.data_out), 64'h0000);
    tick();
    ifc.write_reg_enable = 1'b0;
    check_eq("wr_rd_new", 64'(ifc.data_out), 64'h1234);
    // MOVE R2 <- R1 via PASS
    alu_exec(16'h9109, ALU_PASS);
    check_reg("move_pass_r2", 2, 16'h1234);

    // Address mux
    load_ir(16'h8265);
    ifc.addr_sel = 1'b1;
    #1 check_eq("addr_sel_mem", 64'(ifc.ram_addr), 64'h05);
    ifc.addr_sel = 1'b0;

    // PC count and wrap
    ifc.pc_enable = 1'b1;
    repeat (31) tick();
    check_eq("pc_31", 64'(ifc.ram_addr), 64'd31);
    tick();
    check_eq("pc_wrap", 64'(ifc.ram_addr), 64'd0);
    // IR load and PC increment on the same edge
    ifc.data_in = 16'h0117; ifc.ir_enable = 1'b1;
    tick();
    ifc.ir_enable = 1'b0;
    check_eq("pc_inc_ir", 64'(ifc.ram_addr), 64'd1);
    check_eq("dec_branch", 64'(ifc.decoded_instruction), 64'(I_BRANCH));
    ifc.branch = 1'b1;
    tick();
    ifc.branch = 1'b0; ifc.pc_enable = 1'b0;
    check_eq("pc_branch", 64'(ifc.ram_addr), 64'd23);

    // Reset mid-operation with a pending write
    set_reg(1, 16'hAAAA);
    alu_exec(16'hA239, ALU_SUB);
    load_ir(16'h8120);
    ifc.data_in = 16'h5555; ifc.c_sel = 1'b0;
    ifc.write_reg_enable = 1'b1; ifc.pc_enable = 1'b1;
    #2 rst_n = 1'b0;
    ifc.write_reg_enable = 1'b0; ifc.pc_enable = 1'b0;
    #1;
    check_eq("mid_rst_pc", 64'(ifc.ram_addr), 64'h0);
    check_eq("mid_rst_dec", 64'(ifc.decoded_instruction), 64'(I_NOP));
    check_eq("mid_rst_flags", 64'(flags()), 64'h0);
    tick();
    rst_n = 1'b1;
    check_reg("mid_rst_r0", 0, 16'h0000);
    check_reg("mid_rst_r1", 1, 16'h0000);
    check_reg("mid_rst_r2", 2, 16'h0000);
    check_reg("mid_rst_r3", 3, 16'h0000);
    ifc.pc_enable = 1'b1;
    tick();
    ifc.pc_enable = 1'b0;
    check_eq("post_rst_pc", 64'(ifc.ram_addr), 64'd1);

    // Large configuration: LOAD R7 from 0xC4
    ifl.data_in = 32'h810007C4; ifl.ir_enable = 1'b1;
    tick();
    ifl.ir_enable = 1'b0;
    check_eq("lg_dec_load", 64'(ifl.decoded_instruction), 64'(I_LOAD));
    ifl.addr_sel = 1'b1;
    #1 check_eq("lg_addr", 64'(ifl.ram_addr), 64'hC4);
    ifl.data_in = 32'hDEADBEEF; ifl.c_sel = 1'b0; ifl.write_reg_enable = 1'b1;
    tick();
    ifl.write_reg_enable = 1'b0; ifl.addr_sel = 1'b0;
    ifl.data_in = 32'h820007C4; ifl.ir_enable = 1'b1;
    tick();
    ifl.ir_enable = 1'b0;
    check_eq("lg_r7", 64'(ifl.data_out), 64'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ks_data_path_gen.md
# ks_data_path_gen

Parametrised next-generation K&S data path: program counter, instruction register, decoder, multi-port register file, ALU with flag register, and the address/write-back muxes. Generalised in data width, register count and memory address width, and adds XOR, logical shift-left and shift-right, plus a pass-through operation. Sits between the K&S control unit, which drives the enables, mux selects and operation, and the unified program/data RAM.

## Interface
- DATA_W, 16, datapath, register and instruction width; ≥ 16.
- NUM_REGS, 4, register count; power of two, ≥ 2. REG_W = $clog2(NUM_REGS).
- ADDR_W, 5, RAM address / PC width.
- Legality: 3·REG_W ≤ DATA_W−8 and ADDR_W+REG_W ≤ DATA_W−8. Elaboration-time `$error` otherwise.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable  in  1 each  control-unit strobes.
- operation  in  3  ALU op (alu_op_t).
- data_in  in  DATA_W  RAM read data.
- decoded_instruction  out  decoded_instruction_type  current IR decode.
- zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags.
- ram_addr  out  ADDR_W  addr_sel ? mem_addr : pc.
- data_out  out  DATA_W  bus_a (store data).

## Operation
- **IR:** loads data_in when ir_enable.
- **Opcode and fields:** opcode = IR[DATA_W-1:DATA_W-8].
  - LOAD 0x81: c = IR[ADDR_W+REG_W-1:ADDR_W], mem_addr = IR[ADDR_W-1:0].
  - STORE 0x82: a = IR[ADDR_W+REG_W-1:ADDR_W], mem_addr = IR[ADDR_W-1:0].
  - MOVE 0x91: c = IR[2REG_W-1:REG_W], a = b = IR[REG_W-1:0].
  - Three-register ALU ops: a = IR[REG_W-1:0], b = IR[2REG_W-1:REG_W], c = IR[3REG_W-1:2REG_W]. Opcodes: ADD 0xA1, SUB 0xA2, AND 0xA3, OR 0xA4, XOR 0xA5, SHL 0xA6, SHR 0xA7.
  - Branches: mem_addr = IR[ADDR_W-1:0]. Opcodes: BRANCH 0x01, BZERO 0x02, BNEG 0x03, BOV 0x05, BNOV 0x06, BNNEG 0x0A, BNZERO 0x0B.
  - HALT 0xFF. Any other opcode → I_NOP.
  - Unused register/address fields decode to 0.
- **PC:**
  - pc_enable & branch → pc = mem_addr.
  - pc_enable & !branch → pc + 1, wrapping from 2^ADDR_W−1 to 0.
- **Register file:**
  - Two combinational read ports (a, b); one write port (c) on write_reg_enable.
  - bus_c = c_sel ? alu_out : data_in.
  - Read of a register written in the same cycle returns the old value; no bypass.
- **ALU (combinational):**
  - 000 OR; 001 ADD; 010 SUB (a + ~b + 1); 011 AND; 100 XOR.
  - 101 SHL: a<<1, LSB 0. 110 SHR: a>>1 logical, MSB 0. 111 PASS: a.
- **Flags:**
  - zero = (alu_out == 0); neg = alu_out[DATA_W-1].
  - ADD: unsigned_overflow = carry out; signed_overflow = carry-in(MSB) ^ carry-out.
  - SUB: unsigned_overflow = borrow (a <u b); signed_overflow = sign rule on a − b.
  - SHL: unsigned_overflow = a[DATA_W-1]. SHR: unsigned_overflow = a[0]. signed_overflow = 0 for both shifts.
  - Logical ops and PASS: both overflow flags 0.
  - All four flags latch together on flags_reg_enable only.

## Timing
- **Reset (async):**
  - PC = 0, IR = 0 (decodes I_NOP), all registers = 0, all flags = 0.
  - ram_addr = 0 with addr_sel=0.
  - Reset mid-operation discards the pending write; first posedge after release is a normal cycle.
- **Combinational, same cycle:** decoded_instruction, ram_addr, data_out, alu_out.
- **One cycle after the enabling edge:** IR, PC, register, flag updates visible.
- **Simultaneous enables:** ir_enable + pc_enable, and write_reg_enable + flags_reg_enable, all take effect on the same edge. PC and IR never interact within a cycle.

## Structure
- k_and_s_pkg extended with:
  - decoded_instruction_type additions I_XOR, I_SHL, I_SHR;
  - opcode localparams;
  - alu_op_t enum (3 bits).
- One sub-module: ks_alu #(DATA_W), producing alu_out and the four flag precursors. Register file, PC, IR and decoder stay in ks_data_path_gen.

## Test plan
- **Reset:** reset asserted mid-run → PC = 0, R0–R3 = 0, flags 0, decoded_instruction = I_NOP. Release → next pc_enable gives PC = 1.
- **ADD overflow (default params):** R1 = 0x7FFF, R2 = 0x0001, ADD R3 = R1 + R2 → R3 = 0x8000, neg = 1, signed_overflow = 1, unsigned_overflow = 0. Then 0xFFFF + 0x0001 → result 0, zero = 1, unsigned_overflow = 1.
- **SUB borrow:** 0x0003 − 0x0005 → 0xFFFE, unsigned_overflow = 1, neg = 1, signed_overflow = 0. Equal operands → zero = 1.
- **Shifts:** SHL of 0x8001 → 0x0002, unsigned_overflow = 1. SHR of 0x8001 → 0x4000, unsigned_overflow = 1.
- **PC and branch:** PC wraps 31 → 0 on pc_enable. BRANCH 0x0117 with branch = 1 → PC = 23. Same-cycle write/read of one register → read returns the old value.
- **Large config:** DATA_W = 32, NUM_REGS = 8, ADDR_W = 8 → LOAD to R7 from address 0xC4 works. Illegal combination (DATA_W = 16, NUM_REGS = 8) → elaboration error.
